// File: rtl/sensor_arbiter_pkg.sv
// sensor_arbiter_pkg: shared constants for the sensor decoder arbiter.
//   FSM state encoding, locally handled command codes and canned response bytes.
package sensor_arbiter_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ACCEPT  = 3'd1;
   localparam logic [2:0] S_GAP     = 3'd2;
   localparam logic [2:0] S_ISSUE   = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_RESPOND = 3'd5;

   localparam logic [7:0] CMD_MON_A    = 8'h03;
   localparam logic [7:0] CMD_MON_B    = 8'h04;
   localparam logic [7:0] RSP_MON_DATA = 8'hEA;
   localparam logic [7:0] RSP_MON_CODE = 8'hEC;
   localparam logic [7:0] RSP_TO_CODE  = 8'hEE;
   localparam logic [7:0] RSP_TO_DATA  = 8'hFF;

   // Streaming-monitor commands are answered locally without touching the decoder.
   function automatic logic is_monitor(input logic [7:0] cmd);
      return cmd == CMD_MON_A || cmd == CMD_MON_B;
   endfunction

endpackage

// File: rtl/sensor_arbiter_if.sv
// sensor_arbiter_if: requester-side bus of the sensor arbiter.
//   req_valid/req_device/req_command : per-requester request (requester drives)
//   req_ready/rsp_valid              : per-requester accept / response pulses
//   rsp_data/rsp_code                : shared response payload
interface sensor_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [5*NUM_REQ-1:0] req_device;
   logic [8*NUM_REQ-1:0] req_command;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_data;
   logic [7:0]           rsp_code;

   modport master (
      output req_valid, req_device, req_command,
      input  req_ready, rsp_valid, rsp_data, rsp_code
   );

   modport slave (
      input  req_valid, req_device, req_command,
      output req_ready, rsp_valid, rsp_data, rsp_code
   );
endinterface

// File: rtl/sensor_arbiter_rr_picker.sv
// rr_picker: combinational round-robin choice.
//   valid  : request vector
//   ptr    : index of the last winner
//   winner : first valid index after ptr, wrapping (ptr itself has lowest priority)
module rr_picker #(
   parameter  int NUM_REQ = 4,
   localparam int W       = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [W-1:0]       ptr,
   output logic [W-1:0]       winner
);
   logic [W-1:0] idx;

   // Scan farthest-first so the nearest valid index after ptr is written last.
   always_comb begin
      winner = ptr;
      idx = ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = W'((int'(ptr) + k) % NUM_REQ);
         if (valid[idx]) winner = idx;
      end
   end
endmodule

// File: rtl/sensor_arbiter.sv
// sensor_arbiter: shares one sensor decoder between NUM_REQ requesters.
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   bus (slave)             : requester handshake and response payload
//   dec_enable/selector/req : decoder transaction (selector one-hot by device)
//   dec_response/code/fin   : decoder result, completion is a rising edge of dec_finished
//   busy                    : high whenever a transaction is in progress
module sensor_arbiter
   import sensor_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int MIN_GAP_CYCLES = 100000000,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                   clock,
   input  logic                   reset_n,
   sensor_arbiter_if.slave        bus,
   output logic                   dec_enable,
   output logic [31:0]            dec_device_selector,
   output logic [7:0]             dec_request,
   input  logic [7:0]             dec_response,
   input  logic [7:0]             dec_response_code,
   input  logic                   dec_finished,
   output logic                   busy
);
   localparam int W  = $clog2(NUM_REQ);
   localparam int GW = $clog2(MIN_GAP_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [2:0]    state;
   logic [W-1:0]  winner, rr_ptr, pick;
   logic [4:0]    device, cur_dev;
   logic [7:0]    command, cur_cmd, rsp_data_q, rsp_code_q;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] to_cnt;
   logic          fin_q, used, gap_sat;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid  (bus.req_valid),
      .ptr    (rr_ptr),
      .winner (pick)
   );

   always_comb begin
      cur_dev = '0;
      cur_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (winner == W'(i)) begin
            cur_dev = bus.req_device[5*i +: 5];
            cur_cmd = bus.req_command[8*i +: 8];
         end
   end

   assign gap_sat             = gap_cnt >= GW'(MIN_GAP_CYCLES);
   assign busy                = state != S_IDLE;
   assign dec_enable          = state == S_ISSUE || state == S_WAIT;
   assign dec_device_selector = dec_enable ? 32'd1 << device : '0;
   assign dec_request         = dec_enable ? command : '0;
   assign bus.req_ready       = state == S_ACCEPT ? NUM_REQ'(1) << winner : '0;
   assign bus.rsp_valid       = state == S_RESPOND ? NUM_REQ'(1) << winner : '0;
   assign bus.rsp_data        = rsp_data_q;
   assign bus.rsp_code        = rsp_code_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         winner     <= '0;
         rr_ptr     <= W'(NUM_REQ - 1);
         device     <= '0;
         command    <= '0;
         gap_cnt    <= GW'(MIN_GAP_CYCLES);
         to_cnt     <= '0;
         fin_q      <= 1'b0;
         used       <= 1'b0;
         rsp_data_q <= '0;
         rsp_code_q <= '0;
      end else begin
         fin_q   <= dec_finished;
         // Idle time is measured from the end of the last decoder transaction.
         gap_cnt <= (state == S_RESPOND && used) ? '0 : gap_sat ? gap_cnt : gap_cnt + 1'b1;
         case (state)
            S_IDLE:
               if (|bus.req_valid) begin
                  winner <= pick;
                  state  <= S_ACCEPT;
               end
            S_ACCEPT: begin
               device  <= cur_dev;
               command <= cur_cmd;
               used    <= !is_monitor(cur_cmd);
               if (is_monitor(cur_cmd)) begin
                  rsp_data_q <= RSP_MON_DATA;
                  rsp_code_q <= RSP_MON_CODE;
                  state      <= S_RESPOND;
               end else
                  state <= gap_sat ? S_ISSUE : S_GAP;
            end
            S_GAP:
               if (gap_sat) state <= S_ISSUE;
            S_ISSUE: begin
               to_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT:
               // Completion is checked first so it wins over a simultaneous timeout.
               if (dec_finished && !fin_q) begin
                  rsp_data_q <= dec_response;
                  rsp_code_q <= dec_response_code;
                  state      <= S_RESPOND;
               end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data_q <= RSP_TO_DATA;
                  rsp_code_q <= RSP_TO_CODE;
                  state      <= S_RESPOND;
               end else
                  to_cnt <= to_cnt + 1'b1;
            S_RESPOND: begin
               rr_ptr <= winner;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sensor_arbiter.sv
// tb_sensor_arbiter: directed scoreboard bench for sensor_arbiter (gap 20, timeout 50).
//   A decoder model answers 3 cycles after enable with data = cmd^0x18 and
//   code = 0x12 + cmd + device, unless held high or told never to finish.
module tb_sensor_arbiter;
   localparam int N = 4;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic [7:0] code;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        dec_enable, busy;
   logic [31:0] dec_device_selector;
   logic [7:0]  dec_request;
   logic [7:0]  dec_response = '0, dec_response_code = '0;
   logic        dec_finished = 1'b0;
   logic        dec_hold = 1'b0, dec_never = 1'b0, en_prev = 1'b0;

   exp_t        sb[$];
   exp_t        e_mon;
   int          grants[$], rdy_cyc[$], rsp_cyc[$], en_cyc[$], en_len[$];
   logic [31:0] en_sel[$];
   logic [7:0]  en_req[$];
   int          checks = 0, errors = 0, cyc = 0, en_run = 0, en_cnt = 0;
   int          bg, br, bs, be, bl, s, n;

   sensor_arbiter_if #(.NUM_REQ(N)) bus ();

   sensor_arbiter #(.NUM_REQ(N), .MIN_GAP_CYCLES(20), .TIMEOUT_CYCLES(50)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .bus                 (bus),
      .dec_enable          (dec_enable),
      .dec_device_selector (dec_device_selector),
      .dec_request         (dec_request),
      .dec_response        (dec_response),
      .dec_response_code   (dec_response_code),
      .dec_finished        (dec_finished),
      .busy                (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   function automatic int onehot_idx(input logic [31:0] v);
      for (int i = 0; i < 32; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decoder model.
   always @(negedge clock) begin
      if (dec_hold) dec_finished = 1'b1;
      else if (dec_enable && !dec_never) begin
         en_cnt++;
         dec_finished = en_cnt == 3;
         dec_response = dec_request ^ 8'h18;
         dec_response_code = 8'h12 + dec_request + 8'(onehot_idx(dec_device_selector));
      end else begin
         en_cnt = 0;
         dec_finished = 1'b0;
      end
   end

   // Monitor and scoreboard.
   always @(negedge clock) begin
      if (|bus.rsp_valid) begin
         rsp_cyc.push_back(cyc);
         if (sb.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
         else begin
            e_mon = sb.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 32'd1 << e_mon.idx);
            check("rsp_data", 32'(bus.rsp_data), 32'(e_mon.data));
            check("rsp_code", 32'(bus.rsp_code), 32'(e_mon.code));
         end
      end
      if (|bus.req_ready) begin
         grants.push_back(onehot_idx(32'(bus.req_ready)));
         rdy_cyc.push_back(cyc);
      end
      if (dec_enable && !en_prev) begin
         en_cyc.push_back(cyc);
         en_sel.push_back(dec_device_selector);
         en_req.push_back(dec_request);
      end
      if (dec_enable) en_run++;
      else if (en_prev) begin
         en_len.push_back(en_run);
         en_run = 0;
      end
      if (!dec_enable) check("dec_idle_zero", dec_device_selector | 32'(dec_request), 32'd0);
      en_prev = dec_enable;
   end

   task automatic do_reset;
      @(negedge clock);
      reset_n = 1'b0;
      bus.req_valid = '0;
      dec_hold = 1'b0;
      dec_never = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic mark;
      bg = grants.size();
      br = rdy_cyc.size();
      bs = rsp_cyc.size();
      be = en_cyc.size();
      bl = en_len.size();
   endtask

   task automatic check_idle(input string p);
      check({p, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      check({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({p, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
      check({p, "_rsp_code"}, 32'(bus.rsp_code), 32'd0);
      check({p, "_dec_enable"}, 32'(dec_enable), 32'd0);
      check({p, "_dec_sel"}, dec_device_selector, 32'd0);
      check({p, "_dec_req"}, 32'(dec_request), 32'd0);
      check({p, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic set_req(input int i, input logic [4:0] dev, input logic [7:0] cmd);
      bus.req_device[5*i +: 5] = dev;
      bus.req_command[8*i +: 8] = cmd;
      bus.req_valid[i] = 1'b1;
   endtask

   task automatic expect_rsp(input int i, input logic [7:0] d, input logic [7:0] c);
      sb.push_back('{idx: i, data: d, code: c});
   endtask

   // Requesters drop valid on their accept pulse; returns once everything is idle.
   task automatic drain(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clock);
         bus.req_valid &= ~bus.req_ready;
         if (bus.req_valid == '0 && !busy && sb.size() == 0) break;
      end
      check("drain_timeout", 32'(k < budget), 32'd1);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_device = '0;
      bus.req_command = '0;

      // Reset state.
      do_reset;
      #1 check_idle("reset");

      // Single decoder transaction, first after reset so no gap.
      mark;
      @(negedge clock);
      set_req(0, 5'd0, 8'h01);
      expect_rsp(0, 8'h19, 8'h13);
      drain(100);
      check("t1_en_count", 32'(en_cyc.size() - be), 32'd1);
      check("t1_sel", en_sel[be], 32'h0000_0001);
      check("t1_req", 32'(en_req[be]), 32'h01);
      check("t1_no_gap", 32'(en_cyc[be] - rdy_cyc[br]), 32'd1);
      repeat (5) @(negedge clock);
      check("t1_data_held", 32'(bus.rsp_data), 32'h19);
      check("t1_code_held", 32'(bus.rsp_code), 32'h13);

      // Two simultaneous requesters: order 1 then 2, gap enforced before the second.
      do_reset;
      mark;
      @(negedge clock);
      set_req(1, 5'd5, 8'h10);
      set_req(2, 5'd31, 8'h22);
      expect_rsp(1, 8'h08, 8'h27);
      expect_rsp(2, 8'h3A, 8'h53);
      drain(300);
      check("t2_grant0", 32'(grants[bg]), 32'd1);
      check("t2_grant1", 32'(grants[bg+1]), 32'd2);
      check("t2_sel0", en_sel[be], 32'h0000_0020);
      check("t2_sel1", en_sel[be+1], 32'h8000_0000);
      check("t2_gap_ok", 32'(en_cyc[be+1] - rsp_cyc[bs] >= 20), 32'd1);

      // All four held valid with monitor commands: strict rotation.
      do_reset;
      mark;
      @(negedge clock);
      set_req(0, 5'd1, 8'h03);
      set_req(1, 5'd2, 8'h04);
      set_req(2, 5'd3, 8'h03);
      set_req(3, 5'd4, 8'h04);
      expect_rsp(0, 8'hEA, 8'hEC);
      expect_rsp(1, 8'hEA, 8'hEC);
      expect_rsp(2, 8'hEA, 8'hEC);
      expect_rsp(3, 8'hEA, 8'hEC);
      expect_rsp(0, 8'hEA, 8'hEC);
      n = 0;
      for (int k = 0; k < 100 && n < 5; k++) begin
         @(negedge clock);
         if (|bus.req_ready) n++;
      end
      bus.req_valid = '0;
      check("t3_five_grants", 32'(n), 32'd5);
      drain(50);
      check("t3_g0", 32'(grants[bg]), 32'd0);
      check("t3_g1", 32'(grants[bg+1]), 32'd1);
      check("t3_g2", 32'(grants[bg+2]), 32'd2);
      check("t3_g3", 32'(grants[bg+3]), 32'd3);
      check("t3_g4", 32'(grants[bg+4]), 32'd0);
      check("t3_no_decoder", 32'(en_cyc.size() - be), 32'd0);

      // Local rejection latency.
      do_reset;
      mark;
      @(negedge clock);
      s = cyc;
      set_req(3, 5'd7, 8'h04);
      expect_rsp(3, 8'hEA, 8'hEC);
      drain(20);
      check("t4_ready_lat", 32'(rdy_cyc[br] - s), 32'd1);
      check("t4_rsp_lat", 32'(rsp_cyc[bs] - s), 32'd2);
      check("t4_no_decoder", 32'(en_cyc.size() - be), 32'd0);

      // Finished held high from before ISSUE: only the timeout can end it.
      do_reset;
      dec_hold = 1'b1;
      @(negedge clock);
      mark;
      set_req(0, 5'd2, 8'h05);
      expect_rsp(0, 8'hFF, 8'hEE);
      drain(200);
      check("t5_en_len", 32'(en_len[bl]), 32'd51);

      // Reset while waiting on a silent decoder: everything drops, no response.
      dec_hold = 1'b0;
      dec_never = 1'b1;
      mark;
      set_req(1, 5'd3, 8'h06);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         bus.req_valid &= ~bus.req_ready;
         if (dec_enable) begin
            n = 1;
            break;
         end
      end
      check("t6_enable_seen", 32'(n), 32'd1);
      repeat (5) @(negedge clock);
      reset_n = 1'b0;
      #1 check_idle("midreset");
      bus.req_valid = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (60) @(negedge clock);
      check("t6_no_rsp", 32'(rsp_cyc.size() - bs), 32'd0);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
